// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//
// Contents:
//   uart_tx_state_t - transmitter FSM state encoding
//   UartDataBits    - default data bits per frame (matches TX FIFO width)
//   UartDivWidth    - default width of the baud divisor
//
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UartDataBits = 8;
    localparam int UartDivWidth = 16;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer.
//
// Drains the TX FIFO one byte per frame and drives the serial line with a
// start bit, DATA_BITS data bits (LSB first), optional parity and 1 or 2
// stop bits. One bit time is div+1 clocks; div and nstop are latched when
// the byte is loaded, so mid-frame changes only affect the next frame.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous active-high reset
//   tx_en        - transmitter enable; checked only between frames
//   nstop        - 0 = one stop bit, 1 = two stop bits
//   div          - baud divisor, bit time = div+1 clocks
//   fifo_empty   - TX FIFO empty flag (only looked at in IDLE)
//   fifo_rd_data - FIFO read data, valid the cycle after fifo_rd_en
//   parity_en    - (UART_TX_PARITY_EN only) insert a parity bit
//   parity_odd   - (UART_TX_PARITY_EN only) odd instead of even parity
//   fifo_rd_en   - single-cycle FIFO pop strobe (registered)
//   txd          - serial output, idles high (registered)
//   busy         - high from the pop until the end of the stop bit(s)
//
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UartDataBits,
    parameter int DIV_WIDTH = UartDivWidth
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 nstop,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rd_data,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_en,
    input  logic                 parity_odd,
`endif
    output logic                 fifo_rd_en,
    output logic                 txd,
    output logic                 busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_tx_state_t       state_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 nstop_reg;
    logic                 stop2_reg;      // first stop bit done, sending second
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic                 txd_reg;
    logic                 rd_en_reg;
    logic                 busy_reg;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_en_reg;
    logic                 parity_bit_reg;
`endif

    // End of the current bit time.
    assign tick       = (cnt_reg == div_reg);
    assign shift_next = shift_reg >> 1;

    // Outputs are flops: each register is loaded with the value that belongs
    // to the state being entered, so pin timing lines up with state_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            div_reg        <= '0;
            nstop_reg      <= 1'b0;
            stop2_reg      <= 1'b0;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            txd_reg        <= 1'b1;
            rd_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_reg  <= 1'b0;
            parity_bit_reg <= 1'b0;
`endif
        end else begin
            rd_en_reg <= 1'b0;
            // Free-running bit-time counter; held at zero outside the frame.
            cnt_reg   <= tick ? '0 : cnt_reg + DIV_WIDTH'(1);

            case (state_reg)
                IDLE: begin
                    cnt_reg  <= '0;
                    txd_reg  <= 1'b1;
                    busy_reg <= 1'b0;
                    if (tx_en && !fifo_empty) begin
                        state_reg <= POP;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end

                POP: begin
                    cnt_reg   <= '0;
                    state_reg <= LOAD;
                end

                LOAD: begin
                    cnt_reg        <= '0;
                    shift_reg      <= fifo_rd_data;
                    div_reg        <= div;
                    nstop_reg      <= nstop;
                    stop2_reg      <= 1'b0;
                    bit_idx_reg    <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_en_reg  <= parity_en;
                    parity_bit_reg <= (^fifo_rd_data) ^ parity_odd;
`endif
                    txd_reg        <= 1'b0;
                    state_reg      <= START;
                end

                START: begin
                    if (tick) begin
                        txd_reg   <= shift_reg[0];
                        state_reg <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            if (parity_en_reg) begin
                                txd_reg   <= parity_bit_reg;
                                state_reg <= PARITY;
                            end else begin
                                txd_reg   <= 1'b1;
                                state_reg <= STOP;
                            end
`else
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            shift_reg   <= shift_next;
                            txd_reg     <= shift_next[0];
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        txd_reg   <= 1'b1;
                        state_reg <= STOP;
                    end
                end
`endif

                STOP: begin
                    txd_reg <= 1'b1;
                    if (tick) begin
                        if (nstop_reg && !stop2_reg) begin
                            stop2_reg <= 1'b1;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    txd_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_reg;
    assign txd        = txd_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// A small FIFO model feeds the DUT; each frame's line waveform is compared
// cycle by cycle against the expected start/data/parity/stop pattern.
// Optional feature macro: UART_TX_PARITY_EN (parity frames are added).
module tb_uart_tx;

    logic        clock;
    logic        reset;
    logic        tx_en;
    logic        nstop;
    logic [15:0] div;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        txd;
    logic        busy;
`ifdef UART_TX_PARITY_EN
    logic        parity_en;
    logic        parity_odd;
`endif

    int tests_run = 0;
    int fails     = 0;

    // FIFO model
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (fifo_rd_en) begin
            pop_count <= pop_count + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_rd_data <= mem[rd_ptr % 64];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    uart_tx dut (
        .clock        (clock),
        .reset        (reset),
        .tx_en        (tx_en),
        .nstop        (nstop),
        .div          (div),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
`ifdef UART_TX_PARITY_EN
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
`endif
        .fifo_rd_en   (fifo_rd_en),
        .txd          (txd),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits (bounded) for a pop, then checks the LOAD cycle, the whole frame
    // waveform and the first idle cycle after it. par < 0 means no parity bit.
    task automatic run_frame(input string tag, input logic [7:0] b, input int d,
                             input int ns, input int par, input int budget,
                             input bit mutate, input bit drop_en);
        int waited;
        int bad;
        int busy_bad;
        int pops0;
        int nbits;
        int len;
        int bi;
        logic e;
        waited   = 0;
        bad      = 0;
        busy_bad = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (fifo_rd_en !== 1'b1 && waited < budget);
        chk({tag, " pop"}, {31'd0, fifo_rd_en}, 32'd1);
        if (fifo_rd_en !== 1'b1) return;
        pops0 = pop_count;
        chk({tag, " pop_state"}, {29'd0, fifo_rd_en, txd, busy}, 32'b111);
        @(negedge clock);
        chk({tag, " load_state"}, {29'd0, fifo_rd_en, txd, busy}, 32'b011);
        nbits = 1 + 8 + ((par >= 0) ? 1 : 0) + ns + 1;
        len   = nbits * (d + 1);
        for (int c = 0; c < len; c++) begin
            @(negedge clock);
            if (c == 0 && mutate) begin
                div   = 16'd7;
                nstop = ~nstop;
            end
            if (c == 0 && drop_en) tx_en = 1'b0;
            bi = c / (d + 1);
            if (bi == 0)                     e = 1'b0;
            else if (bi <= 8)                e = b[bi-1];
            else if (par >= 0 && bi == 9)    e = par[0];
            else                             e = 1'b1;
            if (txd !== e) bad++;
            if (fifo_rd_en !== 1'b0) bad++;
            if (busy !== 1'b1) busy_bad++;
        end
        chk({tag, " wave_errors"}, bad, 0);
        chk({tag, " busy_errors"}, busy_bad, 0);
        chk({tag, " pops"}, pop_count - pops0, 1);
        @(negedge clock);
        chk({tag, " idle_after"}, {29'd0, fifo_rd_en, txd, busy}, 32'b010);
    endtask

    initial begin
        int bad;
        int pops0;
        int waited;
        reset = 1'b1;
        tx_en = 1'b0;
        nstop = 1'b0;
        div   = 16'd3;
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("reset_outputs", {29'd0, fifo_rd_en, txd, busy}, 32'b010);
        reset = 1'b0;
        @(negedge clock);

        // 0xA5, div=3, one stop bit: 40-cycle frame
        tx_en = 1'b1;
        push(8'hA5);
        run_frame("a5_8n1", 8'hA5, 3, 0, -1, 20, 1'b0, 1'b0);

        // 0xA5, two stop bits, div/nstop disturbed mid-frame: 44 cycles
        nstop = 1'b1;
        div   = 16'd3;
        push(8'hA5);
        run_frame("a5_8n2_mut", 8'hA5, 3, 1, -1, 20, 1'b1, 1'b0);

        // empty FIFO for 50 cycles: no pop, line idle
        nstop = 1'b0;
        div   = 16'd3;
        bad   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("empty_idle_errors", bad, 0);

        // back-to-back at div=0: the second pop must follow the idle cycle
        div = 16'd0;
        pops0 = pop_count;
        push(8'h00);
        push(8'hFF);
        run_frame("b2b_00", 8'h00, 0, 0, -1, 20, 1'b0, 1'b0);
        run_frame("b2b_ff", 8'hFF, 0, 0, -1, 1, 1'b0, 1'b0);
        chk("b2b_total_pops", pop_count - pops0, 2);

        // reset during DATA bit 3 of 0xF7, then fresh frame with 0x3C
        div = 16'd3;
        push(8'hF7);
        push(8'h3C);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (fifo_rd_en !== 1'b1 && waited < 20);
        chk("rst_pop", {31'd0, fifo_rd_en}, 32'd1);
        repeat (2 + 16) @(negedge clock);
        chk("rst_bit3_low", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_frame", {29'd0, fifo_rd_en, txd, busy}, 32'b010);
        @(negedge clock);
        chk("rst_hold_nopop", {29'd0, fifo_rd_en, txd, busy}, 32'b010);
        reset = 1'b0;
        run_frame("after_rst_3c", 8'h3C, 3, 0, -1, 5, 1'b0, 1'b0);

        // tx_en dropped during START: frame completes, no further pop
        push(8'h11);
        push(8'h22);
        run_frame("txen_drop_11", 8'h11, 3, 0, -1, 20, 1'b0, 1'b1);
        pops0 = pop_count;
        bad   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("txen_off_errors", bad, 0);
        chk("txen_off_pops", pop_count - pops0, 0);
        chk("txen_off_fifo_left", wr_ptr - rd_ptr, 1);
        tx_en = 1'b1;
        run_frame("txen_on_22", 8'h22, 3, 0, -1, 5, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
        // even parity of 0x07 (three ones) -> 1; odd parity -> 0
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push(8'h07);
        run_frame("par_even_07", 8'h07, 3, 0, 1, 20, 1'b0, 1'b0);
        parity_odd = 1'b1;
        push(8'h07);
        run_frame("par_odd_07", 8'h07, 3, 0, 0, 20, 1'b0, 1'b0);
        parity_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit serializer: drains the UART TX FIFO and drives the serial line.
- Pops one byte per frame from the FIFO read port and emits start, 8 data bits (LSB first) and 1 or 2 stop bits at a programmable baud divisor.
- Sits between the TX `fifo` instance and the `txd` pin inside the UART peripheral. It is the reader for the FIFO that the bus side writes.

Parameters:
- DATA_BITS, 8, data bits per frame. Must match the TX FIFO DATA_SIZE.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clock, input, 1, system clock. All logic on the rising edge.
- reset, input, 1, synchronous active-high reset.
- tx_en, input, 1, transmitter enable (txctrl.txen).
- nstop, input, 1, 0 = one stop bit, 1 = two stop bits.
- div, input, DIV_WIDTH, baud divisor. Bit time = div+1 clocks.
- fifo_empty, input, 1, TX FIFO empty flag.
- fifo_rd_data, input, DATA_BITS, FIFO read data. Valid the cycle after an fifo_rd_en pulse.
- fifo_rd_en, output, 1, FIFO pop strobe. Single-cycle.
- txd, output, 1, serial line. Idles high.
- busy, output, 1, frame in progress.

Behaviour:
- Reset values: txd=1, fifo_rd_en=0, busy=0, state=IDLE, counters=0, shift register=0.
- Reset is synchronous and wins over everything, including mid-frame. The next edge forces the reset values and drops the partial frame. No FIFO pop occurs in the reset cycle.
- States and outputs:
  - IDLE: txd=1, busy=0. If tx_en & ~fifo_empty, go to POP; otherwise stay.
  - POP: fifo_rd_en=1 for exactly this one cycle, busy=1. Always go to LOAD.
  - LOAD: capture fifo_rd_data into the shift register; latch div and nstop for the whole frame; clear the bit-time counter. Go to START. txd=1.
  - START: txd=0 for div+1 cycles, then go to DATA.
  - DATA: txd=shift[0]. Each div+1 cycles, shift right and increment the bit index. After bit DATA_BITS-1, go to STOP.
  - STOP: txd=1 for (nstop_latched+1)*(div_latched+1) cycles, then go to IDLE.
- txd and fifo_rd_en are driven from flops, so no combinational glitch reaches the pin.
- Bit-time counter:
  - Counts 0..div_latched.
  - A tick fires when counter == div_latched; the counter wraps to 0 on the tick.
  - div=0 gives one clock per bit.
- Changes to div or nstop mid-frame have no effect until the next LOAD.
- tx_en low mid-frame: the current frame completes; no further pop.
- Back-to-back frames: after STOP the block returns to IDLE. With the FIFO non-empty, the idle-high gap between stop end and the next start bit is exactly 3 cycles (IDLE, POP, LOAD).
- The block never asserts fifo_rd_en while fifo_empty=1 is sampled in IDLE. fifo_empty is ignored outside IDLE.
- Frame length from START entry: (1 + DATA_BITS + nstop+1)*(div+1) cycles.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input ports parity_en and parity_odd, both 1 bit and latched at LOAD.
  - When parity_en=1, a PARITY state is inserted between DATA and STOP for one bit time.
  - txd in PARITY = XOR of the data bits, inverted when parity_odd=1.
- Undefined:
  - Ports, state and logic are absent.
  - Frame is 8N1/8N2 only.

Decomposition:
- uart_pkg holds:
  - typedef enum uart_tx_state_t {IDLE, POP, LOAD, START, DATA, PARITY, STOP}. PARITY is present only under the macro.
  - localparam UartDataBits = 8.
  - localparam UartDivWidth = 16.
- No sub-module. The baud counter is inline because the RX side oversamples and does not share it.

Test Plan:
- div=3, nstop=0, FIFO holds 0xA5, tx_en=1 -> one fifo_rd_en pulse; txd 0 for 4 cycles; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; then 1 for 4 cycles; busy high POP..STOP end; START-to-IDLE = 40 cycles.
- Same byte with nstop=1 -> stop high 8 cycles, frame 44 cycles. div changed to 7 mid-frame -> frame timing unchanged.
- tx_en=1, fifo_empty=1 for 50 cycles -> fifo_rd_en never asserted, txd=1, busy=0.
- Bytes 0x00 then 0xFF queued, div=0 -> two 10-cycle frames separated by exactly 3 idle-high cycles; exactly 2 pops.
- reset pulsed during DATA bit 3 -> next edge txd=1, busy=0, fifo_rd_en=0. After release with FIFO non-empty, the next frame starts with a fresh pop.
- tx_en dropped during START -> frame completes, no second pop although the FIFO still holds data. Under UART_TX_PARITY_EN with parity_en=1, parity_odd=0, byte 0x07 -> parity bit 1.
